// File: rtl/uart_autobaud.sv
// Measures the bit period of a 0x55 sync character on RX and yields the baud divider.
// Result or error is pulsed one cycle after the deciding edge or timeout; no backpressure.
module uart_autobaud #(
    parameter int P_DIV_W   = 16,
    parameter int P_MIN_DIV = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_arm,
    input  logic               i_rx,
    output logic [P_DIV_W-1:0] o_divider,
    output logic               o_valid,
    output logic               o_done,
    output logic               o_err,
    output logic               o_busy
);
    localparam int TOT_W = P_DIV_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HIGH,
        ST_WAIT_FALL,
        ST_MEASURE,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic               rx_s1_q, rx_s1_d;
    logic               rx_s2_q, rx_s2_d;
    logic               rx_s3_q, rx_s3_d;
    logic [P_DIV_W-1:0] int_cnt_q, int_cnt_d;
    logic [P_DIV_W-1:0] ref_q, ref_d;
    logic [P_DIV_W-1:0] divider_q, divider_d;
    logic [TOT_W-1:0]   tot_cnt_q, tot_cnt_d;
    logic [2:0]         edge_idx_q, edge_idx_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               rx_edge, rx_fall;
    logic [P_DIV_W:0]   len_x, ref_x, diff;
    logic               tol_ok;
    logic [TOT_W-1:0]   div_sum;
    logic [P_DIV_W-1:0] div_val;
    logic               div_small;

    always_comb begin
        rx_s1_d   = i_rx;
        rx_s2_d   = rx_s1_q;
        rx_s3_d   = rx_s2_q;
        rx_edge   = rx_s2_q ^ rx_s3_q;
        rx_fall   = rx_s3_q & ~rx_s2_q;
        len_x     = {1'b0, int_cnt_q};
        ref_x     = {1'b0, ref_q};
        diff      = (len_x >= ref_x) ? (len_x - ref_x) : (ref_x - len_x);
        tol_ok    = (diff <= (ref_x >> 2));
        // tot_cnt spans eight bit times, so +4 then >>3 rounds to nearest
        div_sum   = tot_cnt_q + TOT_W'(4);
        div_val   = div_sum[TOT_W-1:3];
        div_small = (div_val < P_DIV_W'(P_MIN_DIV));
    end

    always_comb begin
        state_d    = state_q;
        int_cnt_d  = int_cnt_q;
        tot_cnt_d  = tot_cnt_q;
        edge_idx_d = edge_idx_q;
        ref_d      = ref_q;
        divider_d  = divider_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_arm) begin
                    state_d = ST_WAIT_HIGH;
                    valid_d = 1'b0;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s2_q) state_d = ST_WAIT_FALL;
            end
            ST_WAIT_FALL: begin
                if (rx_fall) begin
                    state_d    = ST_MEASURE;
                    int_cnt_d  = P_DIV_W'(1);
                    tot_cnt_d  = TOT_W'(1);
                    edge_idx_d = 3'd0;
                    ref_d      = '0;
                end
            end
            ST_MEASURE: begin
                if (!rx_edge) begin
                    if (int_cnt_q == '1) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        int_cnt_d = int_cnt_q + P_DIV_W'(1);
                        tot_cnt_d = tot_cnt_q + TOT_W'(1);
                    end
                end else begin
                    int_cnt_d  = P_DIV_W'(1);
                    tot_cnt_d  = tot_cnt_q + TOT_W'(1);
                    edge_idx_d = edge_idx_q + 3'd1;
                    if (edge_idx_q == 3'd0) begin
                        ref_d = int_cnt_q;
                    end else if (!tol_ok) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (edge_idx_q == 3'd7) begin
                        if (div_small) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                            divider_d = div_val;
                            valid_d   = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            int_cnt_q  <= '0;
            tot_cnt_q  <= '0;
            edge_idx_q <= '0;
            ref_q      <= '0;
            divider_q  <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_s3_q    <= rx_s3_d;
            int_cnt_q  <= int_cnt_d;
            tot_cnt_q  <= tot_cnt_d;
            edge_idx_q <= edge_idx_d;
            ref_q      <= ref_d;
            divider_q  <= divider_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_divider = divider_q;
    assign o_valid   = valid_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: sync characters built from per-interval durations, judged by a
// reference model that decides outcome, pulse latency and divider from the interval list.
module tb_uart_autobaud;
    localparam int W       = 12;
    localparam int MAXC    = (1 << W) - 1;
    localparam int MIN_DIV = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         i_arm;
    logic         i_rx;
    logic [W-1:0] o_divider;
    logic         o_valid;
    logic         o_done;
    logic         o_err;
    logic         o_busy;

    always #5 clock = ~clock;

    uart_autobaud #(.P_DIV_W(W), .P_MIN_DIV(MIN_DIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_arm    (i_arm),
        .i_rx     (i_rx),
        .o_divider(o_divider),
        .o_valid  (o_valid),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_busy   (o_busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int dur[8];
    int m_div = 0;
    int m_valid = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic arm_pulse();
        @(posedge clock); #1 i_arm = 1'b1;
        @(posedge clock); #1 i_arm = 1'b0;
        m_valid = 0;
    endtask

    // kind 0 = success, 1 = error; lat = cycles from start-edge drive to the pulse
    function automatic void model(output int kind, output int lat, output int div);
        int r, tot, dif;
        tot = 0;
        r = dur[0];
        div = 0;
        for (int i = 0; i < 8; i++) begin
            if (dur[i] > MAXC) begin
                kind = 1; lat = tot + MAXC + 3;
                return;
            end
            tot += dur[i];
            dif = (dur[i] > r) ? dur[i] - r : r - dur[i];
            if (i > 0 && dif > r / 4) begin
                kind = 1; lat = tot + 3;
                return;
            end
        end
        div  = (tot + 4) / 8;
        lat  = tot + 3;
        kind = (div < MIN_DIV) ? 1 : 0;
    endfunction

    // arm_mode: 0 none, 1 extra arm mid-measurement, 2 arm in the pulse cycle
    task automatic run_frame(input string tag, input int arm_mode);
        int   kind, lat, div, s, len, n_done, n_err, both, p_lat, arm_iter;
        logic lvl[$];
        model(kind, lat, div);
        s = 4;
        for (int i = 0; i < s; i++) lvl.push_back(1'b1);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < dur[i]; j++) lvl.push_back((i % 2) == 1);
        for (int i = 0; i < 3; i++) lvl.push_back(1'b0);
        len      = s + lat + 8;
        arm_iter = (arm_mode == 1) ? s + 20 : (arm_mode == 2) ? s + lat : -1;
        n_done = 0; n_err = 0; both = 0; p_lat = -1;
        for (int i = 0; i < len; i++) begin
            @(posedge clock); #1;
            i_rx  = (i < lvl.size()) ? lvl[i] : 1'b1;
            i_arm = (i == arm_iter);
            @(negedge clock);
            if (o_done) n_done++;
            if (o_err) n_err++;
            if (o_done && o_err) both++;
            if ((o_done || o_err) && p_lat < 0) p_lat = i - s;
        end
        i_arm = 1'b0;
        if (kind == 0) begin
            m_div = div;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        chk({tag, "/done"}, n_done, (kind == 0) ? 1 : 0);
        chk({tag, "/err"}, n_err, (kind == 1) ? 1 : 0);
        chk({tag, "/excl"}, both, 0);
        chk({tag, "/lat"}, p_lat, lat);
        chk({tag, "/div"}, o_divider, m_div);
        chk({tag, "/valid"}, o_valid, m_valid);
        chk({tag, "/busy"}, o_busy, 0);
    endtask

    initial begin
        int n, j, pulses;
        reset = 1'b1; i_arm = 1'b0; i_rx = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst/div", o_divider, 0);
        chk("rst/valid", o_valid, 0);
        chk("rst/done", o_done, 0);
        chk("rst/err", o_err, 0);
        chk("rst/busy", o_busy, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 8; i++) dur[i] = 868;
        arm_pulse();
        run_frame("b868", 0);

        for (int i = 0; i < 8; i++) dur[i] = (i % 2) ? 11 : 10;
        arm_pulse();
        run_frame("alt10_11", 2);

        for (int i = 0; i < 8; i++) dur[i] = 868;
        dur[4] = 1100;
        arm_pulse();
        run_frame("b3_long", 0);

        for (int i = 0; i < 8; i++) dur[i] = 6;
        arm_pulse();
        run_frame("b6_small", 0);

        for (int i = 0; i < 8; i++) dur[i] = 20;
        dur[0] = 5000;
        arm_pulse();
        run_frame("timeout", 0);

        dur = '{40, 50, 30, 40, 40, 40, 40, 40};
        arm_pulse();
        run_frame("tol_edge", 0);

        // arm while the line is low in mid-character: must sit waiting, no pulses
        @(posedge clock); #1 i_rx = 1'b0;
        arm_pulse();
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (o_done || o_err) pulses++;
        end
        chk("midchar/busy", o_busy, 1);
        chk("midchar/pulses", pulses, 0);
        for (int i = 0; i < 8; i++) dur[i] = 20;
        run_frame("midchar_rearm", 1);

        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(40, 5);
            dur[0] = n;
            for (int i = 1; i < 8; i++) begin
                j = $urandom_range(n / 3, 0);
                dur[i] = ($urandom_range(1, 0) == 1) ? n + j : n - j;
                if (dur[i] < 1) dur[i] = 1;
            end
            arm_pulse();
            run_frame($sformatf("rnd%0d", k), 0);
        end

        // reset mid-measurement after a good result
        for (int i = 0; i < 8; i++) dur[i] = 16;
        arm_pulse();
        run_frame("pre_rst", 0);
        arm_pulse();
        @(posedge clock); #1 i_rx = 1'b0;
        repeat (40) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("midrst/div", o_divider, 0);
        chk("midrst/valid", o_valid, 0);
        chk("midrst/busy", o_busy, 0);
        chk("midrst/done", o_done, 0);
        chk("midrst/err", o_err, 0);
        m_div = 0; m_valid = 0;
        @(posedge clock); #1 reset = 1'b0; i_rx = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (o_done || o_err) pulses++;
        end
        chk("postrst/pulses", pulses, 0);
        chk("postrst/busy", o_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Automatic baud-rate detector for the UART IP. It measures the bit period of an incoming 0x55 sync character on the RX line and produces the system-clock divider factor that the UART clock generator needs for that line. The block sits between the RX pin and the divider configuration of the baud generator, and is armed once per calibration by the host.

## Interface

Parameters:
- P_DIV_W, 16: width of the measured divider and of the per-bit interval counter.
- P_MIN_DIV, 8: smallest acceptable divider; any smaller result is an error.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- i_arm, input, 1: single-cycle request to start a measurement. Ignored unless the block is in IDLE.
- i_rx, input, 1: raw UART RX line, asynchronous to clock, idle high.
- o_divider, output, P_DIV_W: measured clock cycles per bit.
- o_valid, output, 1: high while o_divider holds a successful result from the most recent arm.
- o_done, output, 1: one-cycle pulse on success.
- o_err, output, 1: one-cycle pulse on failure.
- o_busy, output, 1: high in every state except IDLE.

## Operation

Input conditioning:
- i_rx passes through a 2-flop synchroniser, then a third flop for edge detection.
- All three flops reset to 1.
- An edge is any difference between the 2nd and 3rd flop.

State machine:
- IDLE:
  - i_arm moves to WAIT_HIGH.
  - On arm acceptance, o_valid is cleared. o_divider keeps its old value.
- WAIT_HIGH: when the synchronised rx is 1, move to WAIT_FALL. This rejects arming in the middle of a character.
- WAIT_FALL: on a falling edge, move to MEASURE and load int_cnt=1, tot_cnt=1, edge_idx=0, ref=0.
- MEASURE:
  - On a cycle with no edge, int_cnt and tot_cnt each increment by 1.
  - On an edge cycle, the interval is L = int_cnt. Then edge_idx increments, int_cnt reloads to 1, and tot_cnt increments by 1.
  - On the first edge (edge_idx 0→1), ref is set to L.
  - On every later edge, the block checks |L − ref| ≤ ref>>2 using unsigned P_DIV_W+1-bit arithmetic. If the check fails, go to ERR.
  - If int_cnt reaches 2^P_DIV_W − 1 with no edge, go to ERR (timeout).
  - The 8th edge is the falling edge at the start of b7, which is 8 bit times after the start edge.
  - On that edge, compute div = (tot_cnt + 4) >> 3 (round to nearest). tot_cnt is P_DIV_W+3 bits wide.
  - If div < P_MIN_DIV, go to ERR. Otherwise go to DONE.
- DONE:
  - o_divider ← div, o_valid ← 1, o_done = 1 for this cycle only.
  - Next state is IDLE.
- ERR: o_err = 1 for this cycle, o_valid stays 0, next state is IDLE.

Sync character:
- 0x55 is sent LSB first, so the line toggles at every bit boundary from the start bit to b7.
- The block ignores the stop bit and any following idle time.

## Timing

Reset values:
- o_divider = 0, o_valid = 0, o_done = 0, o_err = 0, o_busy = 0.
- State = IDLE.
- All counters = 0.

Latency and pulses:
- Pin to edge detect takes a fixed 2 cycles. This delay is the same for every edge, so it does not bias the measurement.
- o_done and o_err are registered. Each asserts in the cycle after the deciding edge or the timeout cycle, and is never high for more than one cycle.
- o_done and o_err are never high together.

Boundary behaviour:
- i_arm in any state other than IDLE: no effect.
- i_arm in the same cycle as DONE or ERR: no effect. A re-arm is accepted only once the block is back in IDLE.
- Reset asserted mid-measurement: return to IDLE immediately with all outputs at their reset values. No o_done or o_err pulse is generated.
- Exact tolerance bound: |L − ref| = ref>>2 passes.

## Test plan

- 0x55 with every bit exactly 868 cycles (115200 baud at 100 MHz), arm first: tot_cnt = 6944, o_divider = 868, o_valid = 1, and one o_done pulse about 8×868+3 cycles after the start edge.
- 0x55 with alternating 10/11-cycle bits (average 10.5): o_divider = (84+4)>>3 = 11, o_done pulses.
- 0x55 with 868-cycle bits, but b3 stretched to 1100: o_err pulses on the edge ending b3 (|1100−868| = 232 > 217), and o_valid = 0.
- 0x55 with 6-cycle bits: div = 6 < 8, so o_err pulses and o_divider keeps its previous value.
- Arm, drive a falling edge, then hold rx low: o_err pulses when int_cnt reaches 65535, and o_busy then drops.
- Arm mid-character with rx low: the block holds in WAIT_HIGH. Assert reset during MEASURE: all outputs read 0 on the next cycle. A second i_arm while busy is ignored.
